// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: pointer/count width helpers
// and the packed status-flag bundle used by sync_fifo_v2.
package fifo_pkg;

    // Read/write pointer width for a power-of-two depth.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: one extra bit so that "all entries used" is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Idle-timer width large enough to hold the reload value.
    function automatic int tmr_w(input int cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous
// read port. No reset, contents are only meaningful once written.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: store the word on an accepted push.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port is combinational so the head entry is visible without latency.
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with handshake ports, status flags, sticky over/underflow
// errors and a push-idle timeout.
// Build option: define SYNC_FIFO_FWFT_EN for first-word fall-through reads;
// otherwise the popped word is registered onto data_out one cycle after pop.
module sync_fifo_v2
    import fifo_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int AF_LVL      = DEPTH - 2,
    parameter int AE_LVL      = 2,
    parameter int TIMEOUT_CYC = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          data_in,
    input  logic                      push_req,
    output logic                      push_ack,
    input  logic                      pop_req,
    output logic                      pop_ack,
    output logic [WIDTH-1:0]          data_out,
    output logic                      data_out_vld,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      err_clr,
    output logic                      timeout
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam int TW = tmr_w(TIMEOUT_CYC);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LVL);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;
    logic          udf_q,    udf_d;
    logic [TW-1:0] idle_q,   idle_d;

    fifo_flags_t      flags;
    logic             push_hsk;
    logic             pop_hsk;
    logic [WIDTH-1:0] head_word;

    // Status flags are decoded from the registered occupancy only.
    always_comb begin
        flags              = '0;
        flags.full         = (count_q == DEPTH_C);
        flags.empty        = (count_q == '0);
        flags.almost_full  = (count_q >= AF_C);
        flags.almost_empty = (count_q <= AE_C);
    end

    // Acks look at registered state, so a concurrent pop never frees room for
    // a push in the same cycle, and vice versa.
    assign push_ack = push_req & ~flags.full;
    assign pop_ack  = pop_req  & ~flags.empty;
    assign push_hsk = push_ack;
    assign pop_hsk  = pop_ack;

    // Next-state for pointers, occupancy, sticky errors and idle timer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        idle_d   = idle_q;

        if (push_hsk) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_hsk) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push_hsk, pop_hsk})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A new error event wins over a clear arriving in the same cycle.
        if (push_req && flags.full) begin
            ovf_d = 1'b1;
        end else if (err_clr) begin
            ovf_d = 1'b0;
        end

        if (pop_req && flags.empty) begin
            udf_d = 1'b1;
        end else if (err_clr) begin
            udf_d = 1'b0;
        end

        // Any push attempt counts as activity, even one refused while full.
        if (push_req) begin
            idle_d = TMR_LOAD;
        end else if (idle_q != '0) begin
            idle_d = idle_q - TW'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            idle_q   <= TMR_LOAD;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            idle_q   <= idle_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i     (clk),
        .wr_en_i   (push_hsk),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_in),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (head_word)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is presented directly; a pop simply moves on to the next one.
    assign data_out     = head_word;
    assign data_out_vld = ~flags.empty;
`else
    logic [WIDTH-1:0] dout_q,     dout_d;
    logic             dout_vld_q, dout_vld_d;

    // Capture the head word on a pop; otherwise hold the last word read.
    always_comb begin
        dout_d     = dout_q;
        dout_vld_d = pop_hsk;
        if (pop_hsk) begin
            dout_d = head_word;
        end
    end

    // Registered read data and its one-cycle valid strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign data_out     = dout_q;
    assign data_out_vld = dout_vld_q;
`endif

    assign full         = flags.full;
    assign empty        = flags.empty;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign timeout      = (idle_q == '0);

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Self-checking bench for sync_fifo_v2 (default parameters) against a
// queue-based reference model. Honours SYNC_FIFO_FWFT_EN for the read path.
module tb_sync_fifo_v2;

    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;
    localparam int TOUT  = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = '0;
    logic       push_req = 1'b0;
    logic       pop_req = 1'b0;
    logic       err_clr = 1'b0;
    logic       push_ack, pop_ack;
    logic [7:0] data_out;
    logic       data_out_vld;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow, timeout;

    sync_fifo_v2 dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .push_req     (push_req),
        .push_ack     (push_ack),
        .pop_req      (pop_req),
        .pop_ack      (pop_ack),
        .data_out     (data_out),
        .data_out_vld (data_out_vld),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    int         m_idle = 0;
    logic [7:0] m_dout = '0;
    logic       m_vld = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_idle = 0;
        m_dout = '0;
        m_vld  = 1'b0;
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("count", count, n);
        chk("full", full, n == DEPTH);
        chk("empty", empty, n == 0);
        chk("almost_full", almost_full, n >= AF);
        chk("almost_empty", almost_empty, n <= AE);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_udf);
        chk("timeout", timeout, m_idle >= TOUT);
`ifdef SYNC_FIFO_FWFT_EN
        chk("data_out_vld", data_out_vld, n != 0);
        if (n != 0) chk("data_out", data_out, mq[0]);
`else
        chk("data_out_vld", data_out_vld, m_vld);
        chk("data_out", data_out, m_dout);
`endif
    endtask

    // One clock: drive at negedge, check acks, model the posedge, check state.
    task automatic cycle(input logic push, input logic pop, input logic [7:0] din, input logic clr);
        bit was_full, was_empty;
        @(negedge clk);
        push_req = push;
        pop_req  = pop;
        data_in  = din;
        err_clr  = clr;
        #1;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        chk("push_ack", push_ack, push && !was_full);
        chk("pop_ack", pop_ack, pop && !was_empty);
        @(posedge clk);
        if (pop && !was_empty) begin
            m_dout = mq.pop_front();
            m_vld  = 1'b1;
        end else begin
            m_vld  = 1'b0;
        end
        if (push && !was_full) mq.push_back(din);
        if (push && was_full) m_ovf = 1'b1;
        else if (clr)         m_ovf = 1'b0;
        if (pop && was_empty) m_udf = 1'b1;
        else if (clr)         m_udf = 1'b0;
        if (push)               m_idle = 0;
        else if (m_idle < 1000) m_idle++;
        #1;
        check_all();
    endtask

    // Hold reset for two edges, release just after a posedge.
    task automatic do_reset();
        reset    = 1'b1;
        push_req = 1'b0;
        pop_req  = 1'b0;
        err_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
    endtask

    initial begin
        do_reset();

        // Single word in and out (FWFT build: visible before any pop).
        cycle(1'b1, 1'b0, 8'hA5, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);

        // Fill 0x00..0x0F, then overflow attempts.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0);
        cycle(1'b1, 1'b0, 8'h77, 1'b0);
        cycle(1'b1, 1'b0, 8'h78, 1'b1);   // error set beats clear
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b1, 8'h79, 1'b0);   // full: push refused, pop accepted
        cycle(1'b1, 1'b0, 8'h10, 1'b0);

        // Drain in order, then underflow attempts.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 8'h3C, 1'b0);   // empty: pop refused, push accepted
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);

        // Occupancy 5, then simultaneous push/pop across pointer wrap.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 8'($urandom), 1'b0);

        // Random traffic, push-biased then pop-biased.
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 7) == 0);
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0);

        // Idle timeout and recovery.
        cycle(1'b1, 1'b0, 8'h11, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h22, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset asserted in the middle of a burst.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
        @(negedge clk);
        push_req = 1'b1;
        data_in  = 8'h5A;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        push_req = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all();
        for (int i = 0; i < 20; i++)
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_v2.md
SYNC_FIFO_V2 -- requirements
Module: sync_fifo_v2

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, 4..1024.
REQ-003 SHALL have parameter AF_LVL, default DEPTH-2, almost-full threshold on count.
REQ-004 SHALL have parameter AE_LVL, default 2, almost-empty threshold on count.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 7, idle cycles before timeout asserts.
REQ-006 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have ports data_in  in  WIDTH, push_req  in  1, push_ack  out  1: write word and handshake.
REQ-009 SHALL have ports pop_req  in  1, pop_ack  out  1, data_out  out  WIDTH, data_out_vld  out  1: read handshake and data.
REQ-010 SHALL have ports full, empty, almost_full, almost_empty  out  1 each: status flags.
REQ-011 SHALL have port count  out  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have ports overflow, underflow  out  1 each: sticky errors; err_clr  in  1 clears both.
REQ-013 SHALL have port timeout  out  1  no push_req for TIMEOUT_CYC cycles.

Function
REQ-014 SHALL store entries in a circular buffer: wr_ptr, rd_ptr of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0 with no gap.
REQ-015 SHALL drive push_ack = push_req && !full and pop_ack = pop_req && !empty, combinationally; handshake = req && ack.
REQ-016 SHALL update count <= count + push_hsk - pop_hsk each cycle; simultaneous push and pop leave count unchanged, both pointers advance.
REQ-017 SHALL assert full when count == DEPTH (all DEPTH entries usable) and empty when count == 0.
REQ-018 SHALL assert almost_full when count >= AF_LVL and almost_empty when count <= AE_LVL.
REQ-019 SHALL, when full, refuse push even with concurrent pop (ack is registered-state based); when empty, refuse pop even with concurrent push.
REQ-020 SHALL set overflow on push_req && full and underflow on pop_req && empty; both hold until err_clr; set takes priority over clear in the same cycle.
REQ-021 SHALL, non-FWFT mode, register the head word into data_out one cycle after pop_hsk, with data_out_vld high for exactly that one cycle; data_out holds otherwise.
REQ-022 SHALL reload the idle counter to TIMEOUT_CYC on any push_req, else decrement to 0 and saturate; timeout = (counter == 0).

Reset
REQ-023 SHALL on reset clear wr_ptr, rd_ptr, count, data_out, data_out_vld, overflow, underflow, and load idle counter with TIMEOUT_CYC; empty=1, almost_empty=1, full=0, timeout=0.
REQ-024 SHALL abandon any in-flight push/pop when reset asserts mid-operation; storage contents need not be cleared.

Configuration
REQ-025 SHALL compile first-word fall-through when macro SYNC_FIFO_FWFT_EN is defined: data_out = head entry combinationally, data_out_vld = !empty, pop_hsk advances rd_ptr with zero latency.
REQ-026 SHALL without SYNC_FIFO_FWFT_EN use the 1-cycle registered read of REQ-021.

Structure
REQ-027 SHALL place the ptr/count width function and the FIFO status-flag struct typedef in shared package fifo_pkg.
REQ-028 SHALL implement storage as sub-module fifo_ram (1 write, 1 read port, WIDTH x DEPTH, no reset).

Verification
REQ-029 SHALL cover: reset, push 16 words 0x00..0x0F (DEPTH=16) -> full=1 after 16th, count=16, 17th push_ack=0, overflow=1.
REQ-030 SHALL cover: pop 16 words -> data_out 0x00..0x0F in order, each 1 cycle after pop (non-FWFT), empty=1, extra pop -> underflow=1.
REQ-031 SHALL cover: wrap-around, 40 interleaved push/pop with simultaneous handshakes at count=5 -> count stays 5, order preserved across pointer wrap.
REQ-032 SHALL cover: thresholds AF_LVL=14, AE_LVL=2 -> almost_full rises at count 14, almost_empty falls at count 3.
REQ-033 SHALL cover: push_req idle 7 cycles -> timeout=1 on 7th; push_req -> timeout=0 next cycle; reset mid-burst -> count=0, empty=1 immediately.
REQ-034 SHALL cover: FWFT build, single push 0xA5 -> data_out=0xA5, data_out_vld=1 next cycle without pop.
